deconvolve: RTL and testbench

DECONVOLVE -- requirements
Module: deconvolve

---
 rtl/deconvolve.sv | 201 ++++++++++++++++++++
 tb/tb_deconvolve.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/deconvolve.sv
// Streaming deconvolution: recovers x from y = x conv h by forward substitution,
// one multiply-subtract per tap and a 48-step restoring divide per sample.
module deconvolve #(
    parameter int N = 1,
    parameter int M = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [M-1:0][15:0]  arr_M,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int IW = $clog2(N + M) + 1;
    localparam int KW = $clog2(M) + 1;
    localparam logic [IW-1:0] LAST_X = IW'(N - 1);
    localparam logic [IW-1:0] NUM_X  = IW'(N);
    localparam logic [IW-1:0] LAST_Y = IW'(N + M - 2);
    localparam logic [KW-1:0] LAST_K = KW'(M - 1);

    typedef enum logic [2:0] {IDLE, WAIT_IN, MAC, DIV, OUT, CHECK, DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      i_q, i_d;
    logic [KW-1:0]      k_q, k_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [47:0]        acc_q, acc_d;
    logic [47:0]        dq_q, dq_d;
    logic [15:0]        rem_q, rem_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;
    logic [15:0]        xout_q, xout_d;
    logic signed [15:0] h_q [M];
    logic signed [15:0] h_d [M];
    // hist_q[j] holds x[i-1-j]; zero where that sample is out of range
    logic signed [15:0] hist_q [M-1];
    logic signed [15:0] hist_d [M-1];

    logic signed [15:0] h_sel, x_sel;
    logic signed [31:0] prod;
    logic [16:0]        dmag, rem_sh;
    logic [47:0]        dq_sh;
    logic [15:0]        q_sat;
    logic               sat;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        err_d   = err_q;
        xout_d  = xout_q;
        h_d     = h_q;
        hist_d  = hist_q;
        h_sel   = '0;
        x_sel   = '0;
        q_sat   = '0;
        sat     = 1'b0;

        for (int k = 1; k < M; k++) begin
            if (k_q == KW'(k)) begin
                h_sel = h_q[k];
                x_sel = hist_q[k-1];
            end
        end
        prod = h_sel * x_sel;

        dmag   = h_q[0][15] ? (17'd0 - {1'b1, h_q[0]}) : {1'b0, h_q[0]};
        rem_sh = {rem_q, dq_q[47]};
        dq_sh  = {dq_q[46:0], 1'b0};

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < M; k++) h_d[k] = arr_M[k];
                    for (int j = 0; j < M - 1; j++) hist_d[j] = '0;
                    i_d     = '0;
                    acc_d   = '0;
                    err_d   = (arr_M[0] == 16'd0);
                    state_d = (arr_M[0] == 16'd0) ? DONE : WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (in_valid) begin
                    acc_d   = {{16{in_data[31]}}, in_data};
                    k_d     = KW'(1);
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q - {{16{prod[31]}}, prod};
                k_d   = k_q + KW'(1);
                if (k_q == LAST_K) begin
                    if (i_q < NUM_X) begin
                        dq_d    = acc_d[47] ? (48'd0 - acc_d) : acc_d;
                        rem_d   = '0;
                        cnt_d   = '0;
                        neg_d   = acc_d[47] ^ h_q[0][15];
                        state_d = DIV;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            DIV: begin
                if (rem_sh >= dmag) begin
                    rem_d = 16'(rem_sh - dmag);
                    dq_d  = dq_sh | 48'd1;
                end else begin
                    rem_d = rem_sh[15:0];
                    dq_d  = dq_sh;
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd47) begin
                    // dq_d is now the quotient magnitude; apply sign and clamp
                    if (!neg_q) begin
                        sat   = (dq_d > 48'd32767);
                        q_sat = sat ? 16'h7fff : dq_d[15:0];
                    end else begin
                        sat   = (dq_d > 48'd32768);
                        q_sat = sat ? 16'h8000 : 16'(~dq_d[15:0] + 16'd1);
                    end
                    xout_d = q_sat;
                    err_d  = err_q | sat | (rem_d != 16'd0);
                    for (int j = M - 2; j > 0; j--) hist_d[j] = hist_q[j-1];
                    hist_d[0] = q_sat;
                    state_d   = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    i_d     = i_q + IW'(1);
                    state_d = WAIT_IN;
                end
            end
            CHECK: begin
                if (acc_q != 48'd0) err_d = 1'b1;
                for (int j = M - 2; j > 0; j--) hist_d[j] = hist_q[j-1];
                hist_d[0] = '0;
                i_d       = i_q + IW'(1);
                state_d   = (i_q == LAST_Y) ? DONE : WAIT_IN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            xout_q  <= '0;
            for (int k = 0; k < M; k++) h_q[k] <= '0;
            for (int j = 0; j < M - 1; j++) hist_q[j] <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            xout_q  <= xout_d;
            h_q     <= h_d;
            hist_q  <= hist_d;
        end
    end

    assign in_ready  = (state_q == WAIT_IN);
    assign out_valid = (state_q == OUT);
    assign out_last  = (state_q == OUT) && (i_q == LAST_X);
    assign out_data  = xout_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_deconvolve.sv
// Bench for deconvolve: directed frames plus random frames checked against a
// forward-substitution reference model.
module tb_deconvolve;

    localparam int N   = 3;
    localparam int M   = 2;
    localparam int L   = N + M - 1;
    localparam int LAT = 1 + (M - 1) + 48;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [M-1:0][15:0] arr_M = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [15:0]        out_data;
    logic               out_last;
    logic               busy;
    logic               done;
    logic               err;

    int n_checks = 0;
    int n_errors = 0;

    longint hm [M];
    longint ym [L];
    longint exp_x [$];
    bit     exp_err;

    deconvolve #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .arr_M     (arr_M),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Forward substitution: x[i] = (y[i] - sum h[k]x[i-k]) / h[0]; tail residuals must be 0
    function automatic void model();
        longint xs [N];
        longint r, q;
        exp_x.delete();
        exp_err = 1'b0;
        if (hm[0] == 0) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < L; i++) begin
            r = ym[i];
            for (int k = 1; k < M; k++)
                if (i - k >= 0 && i - k < N) r = r - hm[k] * xs[i-k];
            if (i < N) begin
                q = r / hm[0];
                if (r % hm[0] != 0) exp_err = 1'b1;
                if (q > 32767)  begin q = 32767;  exp_err = 1'b1; end
                if (q < -32768) begin q = -32768; exp_err = 1'b1; end
                xs[i] = q;
                exp_x.push_back(q);
            end else if (r != 0) begin
                exp_err = 1'b1;
            end
        end
    endfunction

    task automatic run_frame(input string name, input bit stall);
        int  yi, xi, acc_c, stall_left;
        bit  waiting, got_done;
        yi = 0; xi = 0; acc_c = 0; waiting = 0; got_done = 0;
        stall_left = stall ? 10 : 0;
        for (int k = 0; k < M; k++) arr_M[k] = 16'(hm[k]);
        model();
        @(negedge clk);
        check_val({name, "_idle_busy"}, busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            check_val({name, "_excl"}, in_ready & out_valid, 0);
            in_valid = (yi < L) && ($urandom % 5 != 0);
            in_data  = (yi < L) ? 32'(ym[yi]) : 32'd0;
            if (in_ready && in_valid) begin
                acc_c   = c;
                waiting = (yi < N);
                yi++;
            end
            if (out_valid && waiting) begin
                check_val({name, "_latency"}, c - acc_c, LAT);
                waiting = 0;
            end
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                if (xi < exp_x.size())
                    check_val({name, "_hold_data"}, $signed(out_data), exp_x[xi]);
                check_val({name, "_hold_inready"}, in_ready, 0);
                stall_left--;
            end else begin
                out_ready = ($urandom % 3 != 0);
            end
            if (out_valid && out_ready) begin
                if (xi < exp_x.size()) begin
                    check_val({name, "_x"}, $signed(out_data), exp_x[xi]);
                    check_val({name, "_last"}, out_last, (xi == N - 1) ? 1 : 0);
                end
                xi++;
                check_val({name, "_out_bound"}, (xi <= exp_x.size()) ? 1 : 0, 1);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val({name, "_done_seen"}, got_done, 1);
        check_val({name, "_err"}, err, exp_err);
        check_val({name, "_n_out"}, xi, exp_x.size());
        check_val({name, "_n_in"}, yi, (hm[0] == 0) ? 0 : L);
        $display("frame %s: h0=%0d h1=%0d inputs=%0d outputs=%0d err=%0d", name, hm[0], hm[1], yi, xi, err);
        @(negedge clk);
        check_val({name, "_done_pulse"}, done, 0);
        check_val({name, "_busy_after"}, busy, 0);
    endtask

    task automatic set_frame(input longint h0, input longint h1,
                             input longint y0, input longint y1, input longint y2, input longint y3);
        hm[0] = h0; hm[1] = h1;
        ym[0] = y0; ym[1] = y1; ym[2] = y2; ym[3] = y3;
    endtask

    task automatic reset_test();
        bit bad;
        bad = 0;
        set_frame(1, 2, 3, 10, 13, 10);
        for (int k = 0; k < M; k++) arr_M[k] = 16'(hm[k]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done || in_ready || busy || out_valid) bad = 1;
        end
        in_valid = 1'b0;
        check_val("rst_abort_quiet", bad, 0);
        $display("reset during DIV: outputs cleared, idle held for 80 cycles");
    endtask

    initial begin
        longint xr [N];
        repeat (3) @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_in_ready", in_ready, 0);
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_err", err, 0);
        check_val("reset_out_data", out_data, 0);
        rst = 1'b0;

        set_frame(1, 2, 3, 10, 13, 10);    run_frame("basic", 0);
        set_frame(2, -1, -6, 17, -5, -1);  run_frame("neg", 0);
        set_frame(1, 2, 3, 10, 13, 11);    run_frame("tail", 0);
        set_frame(0, 1, 1, 2, 3, 4);       run_frame("h0zero", 0);
        set_frame(1, 2, 3, 10, 13, 10);    run_frame("stall", 1);
        set_frame(1, 0, 40000, -50000, 7, 0); run_frame("sat", 0);
        set_frame(2, 1, 5, 2, 0, 0);       run_frame("remainder", 0);

        reset_test();

        for (int f = 0; f < 25; f++) begin
            hm[0] = ($urandom % 2 == 0) ? longint'($urandom_range(1, 9))
                                        : longint'($urandom_range(0, 40000)) - 20000;
            if (hm[0] == 0) hm[0] = 1;
            if ($urandom % 2 == 0) hm[0] = -hm[0];
            hm[1] = longint'($urandom_range(0, 40000)) - 20000;
            for (int i = 0; i < N; i++) xr[i] = longint'($urandom_range(0, 65534)) - 32767;
            for (int i = 0; i < L; i++) begin
                ym[i] = 0;
                for (int k = 0; k < M; k++)
                    if (i - k >= 0 && i - k < N) ym[i] = ym[i] + hm[k] * xr[i-k];
            end
            if ($urandom % 3 == 0) ym[$urandom_range(0, L - 1)] += longint'($urandom_range(1, 5));
            run_frame($sformatf("rand%0d", f), ($urandom % 4 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
